// File: rtl/seq_rep_pkg.sv
// Shared defaults, the counter type and a popcount helper for the repetition checker.
package seq_rep_pkg;
    localparam int REP_LEN_DEF = 3;
    localparam int CNT_W_DEF   = 16;
    localparam int POP_W       = 5;

    typedef logic [CNT_W_DEF-1:0] cnt_t;

    function automatic logic [POP_W-1:0] popcount16(input logic [15:0] v);
        logic [POP_W-1:0] c;
        c = '0;
        for (int i = 0; i < 16; i++) c = c + POP_W'(v[i]);
        return c;
    endfunction
endpackage

// File: rtl/sat_counter.sv
// Up-counter that adds a multi-bit increment each cycle and clamps at all-ones.
module sat_counter #(
    parameter int W     = 16,
    parameter int INC_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [INC_W-1:0] inc,
    output logic [W-1:0]     count
);
    // One extra bit beyond the wider operand so the overflow is visible.
    localparam int SW = ((W > INC_W) ? W : INC_W) + 1;
    localparam logic [SW-1:0] MAX = SW'({W{1'b1}});

    logic [SW-1:0] sum;

    always_comb sum = SW'(count) + SW'(inc);

    always_ff @(posedge clk) begin
        if (!rst)            count <= '0;
        else if (sum > MAX)  count <= '1;
        else                 count <= sum[W-1:0];
    end
endmodule

// File: rtl/seq_rep_checker.sv
// Checks that b stays high for REP_LEN edges after each trigger on a, counting passes and fails.
// Optional first-fail capture is enabled with SEQ_REP_CHECKER_FIRST_FAIL_EN.
module seq_rep_checker
    import seq_rep_pkg::*;
#(
    parameter int REP_LEN = REP_LEN_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    output logic             pass_pulse,
    output logic             fail_pulse,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             busy
`ifdef SEQ_REP_CHECKER_FIRST_FAIL_EN
    ,
    output logic             first_fail_vld,
    output logic [CNT_W-1:0] first_fail_cyc
`endif
);
    // The top bit of the age vector is an attempt that just completed; the rest are still pending.
    localparam logic [REP_LEN-1:0] LIVE_MASK = {REP_LEN{1'b1}} >> 1;

    logic [REP_LEN-1:0] age_q, age_d, shifted;
    logic               fail_q, busy_q, fail_now;
    logic [POP_W-1:0]   fail_inc;

    generate
        if (REP_LEN == 1) begin : g_len1
            assign shifted = a;
        end else begin : g_lenn
            assign shifted = {age_q[REP_LEN-2:0], a};
        end
    endgenerate

    always_comb begin
        age_d    = b ? shifted : '0;
        fail_now = !b && (|shifted);
        fail_inc = fail_now ? popcount16(16'(shifted)) : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            age_q  <= '0;
            fail_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            age_q  <= age_d;
            fail_q <= fail_now;
            busy_q <= |(age_d & LIVE_MASK);
        end
    end

    assign pass_pulse = age_q[REP_LEN-1];
    assign fail_pulse = fail_q;
    assign busy       = busy_q;

    sat_counter #(.W(CNT_W), .INC_W(1)) u_pass_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (age_d[REP_LEN-1]),
        .count (pass_cnt)
    );

    sat_counter #(.W(CNT_W), .INC_W(POP_W)) u_fail_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (fail_inc),
        .count (fail_cnt)
    );

`ifdef SEQ_REP_CHECKER_FIRST_FAIL_EN
    logic [CNT_W-1:0] cyc_cnt;
    logic             ff_vld_q;
    logic [CNT_W-1:0] ff_cyc_q;

    sat_counter #(.W(CNT_W), .INC_W(1)) u_cyc_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (1'b1),
        .count (cyc_cnt)
    );

    // Captured on the failing edge itself, so the valid rises together with fail_pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ff_vld_q <= 1'b0;
            ff_cyc_q <= '0;
        end else if (fail_now && !ff_vld_q) begin
            ff_vld_q <= 1'b1;
            ff_cyc_q <= cyc_cnt;
        end
    end

    assign first_fail_vld = ff_vld_q;
    assign first_fail_cyc = ff_cyc_q;
`endif
endmodule

// File: tb/tb_seq_rep_checker.sv
// Randomized and directed bench for seq_rep_checker against an attempt-list reference model.
module tb_seq_rep_checker;
    localparam int REP0 = 3;
    localparam int CW0  = 16;
    localparam int REP1 = 1;
    localparam int CW1  = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic a   = 1'b0;
    logic b   = 1'b0;

    logic            pass0, fail0, busy0, pass1, fail1, busy1;
    logic [CW0-1:0]  pcnt0, fcnt0;
    logic [CW1-1:0]  pcnt1, fcnt1;
`ifdef SEQ_REP_CHECKER_FIRST_FAIL_EN
    logic            ffv0, ffv1;
    logic [CW0-1:0]  ffc0;
    logic [CW1-1:0]  ffc1;
`endif

    always #5 clk = ~clk;

    seq_rep_checker #(.REP_LEN(REP0), .CNT_W(CW0)) dut0 (
        .clk(clk), .rst(rst), .a(a), .b(b),
        .pass_pulse(pass0), .fail_pulse(fail0), .pass_cnt(pcnt0), .fail_cnt(fcnt0), .busy(busy0)
`ifdef SEQ_REP_CHECKER_FIRST_FAIL_EN
        , .first_fail_vld(ffv0), .first_fail_cyc(ffc0)
`endif
    );

    seq_rep_checker #(.REP_LEN(REP1), .CNT_W(CW1)) dut1 (
        .clk(clk), .rst(rst), .a(a), .b(b),
        .pass_pulse(pass1), .fail_pulse(fail1), .pass_cnt(pcnt1), .fail_cnt(fcnt1), .busy(busy1)
`ifdef SEQ_REP_CHECKER_FIRST_FAIL_EN
        , .first_fail_vld(ffv1), .first_fail_cyc(ffc1)
`endif
    );

    logic [63:0] obs [2];
    assign obs[0] = {29'd0, pass0, fail0, busy0, 16'(pcnt0), 16'(fcnt0)};
    assign obs[1] = {29'd0, pass1, fail1, busy1, 16'(pcnt1), 16'(fcnt1)};

    // Reference model: a flat list of live attempts, each tagged with instance and start edge.
    typedef struct {
        int inst;
        int t;
    } att_t;

    att_t live[$];
    int   rep_of [2] = '{REP0, REP1};
    int   max_of [2] = '{(1 << CW0) - 1, (1 << CW1) - 1};
    bit   exp_pass [2], exp_fail [2], exp_busy [2];
    int   exp_pcnt [2], exp_fcnt [2];
    int   exp_cyc [2], exp_ffc [2];
    bit   exp_ffv [2];
    int   edge_no = 0;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic logic [63:0] exp_vec(input int k);
        return {29'd0, exp_pass[k], exp_fail[k], exp_busy[k], 16'(exp_pcnt[k]), 16'(exp_fcnt[k])};
    endfunction

    task automatic model_edge(input bit a_i, input bit b_i, input bit rst_i);
        if (!rst_i) begin
            live.delete();
            for (int k = 0; k < 2; k++) begin
                exp_pass[k] = 0; exp_fail[k] = 0; exp_busy[k] = 0;
                exp_pcnt[k] = 0; exp_fcnt[k] = 0;
                exp_cyc[k]  = 0; exp_ffv[k]  = 0; exp_ffc[k] = 0;
            end
            return;
        end
        for (int k = 0; k < 2; k++) begin
            int   fails;
            bit   passed;
            bit   any_live;
            att_t keep[$];
            fails = 0; passed = 0; any_live = 0;
            if (a_i) live.push_back('{inst: k, t: edge_no});
            foreach (live[j]) begin
                if (live[j].inst != k) keep.push_back(live[j]);
                else if (!b_i) fails++;
                else if (edge_no - live[j].t == rep_of[k] - 1) passed = 1;
                else begin
                    keep.push_back(live[j]);
                    any_live = 1;
                end
            end
            live = keep;
            exp_pass[k] = passed;
            exp_fail[k] = (fails > 0);
            exp_busy[k] = any_live;
            exp_pcnt[k] = (exp_pcnt[k] + int'(passed) > max_of[k]) ? max_of[k] : exp_pcnt[k] + int'(passed);
            exp_fcnt[k] = (exp_fcnt[k] + fails > max_of[k]) ? max_of[k] : exp_fcnt[k] + fails;
            if (exp_fail[k] && !exp_ffv[k]) begin
                exp_ffv[k] = 1;
                exp_ffc[k] = exp_cyc[k];
            end
            exp_cyc[k] = (exp_cyc[k] + 1 > max_of[k]) ? max_of[k] : exp_cyc[k] + 1;
        end
    endtask

    task automatic tick(input bit a_i, input bit b_i, input bit rst_i = 1'b1);
        @(negedge clk);
        a = a_i; b = b_i; rst = rst_i;
        @(posedge clk);
        model_edge(a_i, b_i, rst_i);
        edge_no++;
        #1;
    endtask

    task automatic test_reset();
        tick(1, 1, 0);
        tick(1, 1, 0);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (obs[k] !== 64'd0) $display("FAIL reset_outputs inst%0d got=%h want=0", k, obs[k]);
            else n_pass++;
        end
    endtask

    task automatic test_single_pass();
        bit a_t [6] = '{0, 1, 0, 0, 0, 0};
        bit b_t [6] = '{0, 1, 1, 1, 0, 0};
        int pulses;
        pulses = 0;
        tick(0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            tick(a_t[i], b_t[i]);
            pulses += int'(pass0);
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (obs[k] !== exp_vec(k))
                    $display("FAIL single_pass inst%0d step%0d got=%h want=%h", k, i, obs[k], exp_vec(k));
                else n_pass++;
            end
        end
        n_checks++;
        if (pcnt0 !== 16'd1 || pulses != 1) $display("FAIL single_pass_total got=%0d/%0d want=1/1", pcnt0, pulses);
        else n_pass++;
    endtask

    task automatic test_overlap();
        bit a_t [6] = '{1, 1, 1, 0, 0, 0};
        bit b_t [6] = '{1, 1, 1, 1, 0, 0};
        tick(0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            tick(a_t[i], b_t[i]);
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (obs[k] !== exp_vec(k))
                    $display("FAIL overlap inst%0d step%0d got=%h want=%h", k, i, obs[k], exp_vec(k));
                else n_pass++;
            end
        end
        n_checks++;
        if (pcnt0 !== 16'd2 || fcnt0 !== 16'd1) $display("FAIL overlap_totals got=%0d,%0d want=2,1", pcnt0, fcnt0);
        else n_pass++;
    endtask

    task automatic test_multi_fail();
        bit a_t [4] = '{1, 1, 0, 0};
        bit b_t [4] = '{1, 0, 0, 0};
        int pulses;
        pulses = 0;
        tick(0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick(a_t[i], b_t[i]);
            pulses += int'(fail0);
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (obs[k] !== exp_vec(k))
                    $display("FAIL multi_fail inst%0d step%0d got=%h want=%h", k, i, obs[k], exp_vec(k));
                else n_pass++;
            end
        end
        n_checks++;
        if (fcnt0 !== 16'd2 || pcnt0 !== 16'd0 || pulses != 1)
            $display("FAIL multi_fail_totals got=%0d,%0d,%0d want=2,0,1", fcnt0, pcnt0, pulses);
        else n_pass++;
    endtask

    task automatic test_saturation();
        tick(0, 0, 0);
        for (int i = 0; i < 5; i++) tick(1, 1);
        tick(0, 1);
        n_checks++;
        if (pcnt1 !== 2'd3) $display("FAIL saturation got=%0d want=3", pcnt1);
        else n_pass++;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (obs[k] !== exp_vec(k)) $display("FAIL saturation_model inst%0d got=%h want=%h", k, obs[k], exp_vec(k));
            else n_pass++;
        end
    endtask

    task automatic test_reset_midflight();
        tick(0, 0, 0);
        tick(1, 1);
        tick(1, 1);
        tick(0, 1, 0);
        tick(0, 1);
        tick(0, 1);
        n_checks++;
        if (pcnt0 !== 16'd0 || fcnt0 !== 16'd0 || busy0 !== 1'b0)
            $display("FAIL reset_midflight got=%0d,%0d,%b want=0,0,0", pcnt0, fcnt0, busy0);
        else n_pass++;
    endtask

    task automatic test_random();
        tick(0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            tick(1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0), ($urandom_range(0, 63) != 0));
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (obs[k] !== exp_vec(k))
                    $display("FAIL random inst%0d cyc%0d got=%h want=%h", k, i, obs[k], exp_vec(k));
                else n_pass++;
            end
        end
    endtask

`ifdef SEQ_REP_CHECKER_FIRST_FAIL_EN
    task automatic test_first_fail();
        tick(0, 0, 0);
        for (int i = 0; i < 12; i++) tick(0, 1);
        tick(1, 0);
        for (int i = 0; i < 7; i++) tick(0, 1);
        tick(1, 0);
        tick(0, 1);
        n_checks++;
        if (ffv0 !== 1'b1 || ffc0 !== 16'd12) $display("FAIL first_fail got=%b,%0d want=1,12", ffv0, ffc0);
        else n_pass++;
        n_checks++;
        if (ffv1 !== exp_ffv[1] || ffc1 !== 2'(exp_ffc[1]))
            $display("FAIL first_fail_sat got=%b,%0d want=%b,%0d", ffv1, ffc1, exp_ffv[1], exp_ffc[1]);
        else n_pass++;
        tick(0, 1, 0);
        n_checks++;
        if (ffv0 !== 1'b0 || ffc0 !== 16'd0 || ffv1 !== 1'b0) $display("FAIL first_fail_reset got=%b,%0d want=0,0", ffv0, ffc0);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_single_pass();
        test_overlap();
        test_multi_fail();
        test_saturation();
        test_reset_midflight();
        test_random();
`ifdef SEQ_REP_CHECKER_FIRST_FAIL_EN
        test_first_fail();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
